// File: rtl/lcd_write_sequencer.sv
// lcd_write_sequencer
// 4-bit write-path sequencer for the Spartan-3E character LCD (HD44780).
// After reset it runs the power-on init nibbles and the configuration bytes.
// It then accepts command/data bytes over a valid/ready handshake.
// Each nibble is handed to an external enable-pulse generator via oWriteStart/iWriteDone.
// The settling delays between nibbles and bytes are inserted here.
// Optional feature: define LCD_WRITE_WATCHDOG_EN to add a 100-cycle NIB_WAIT
// watchdog that raises a sticky oError and continues as if the pulse finished.
module lcd_write_sequencer #(
  parameter int T_POWERUP = 750000,
  parameter int T_INIT1   = 205000,
  parameter int T_INIT2   = 5000,
  parameter int T_NIBBLE  = 50,
  parameter int T_CMD     = 2000,
  parameter int T_CLEAR   = 82000,
  parameter int CNT_W     = 20
) (
  input  logic       Clock,
  input  logic       iReset,
  input  logic [7:0] iData,
  input  logic       iRS,
  input  logic       iValid,
  output logic       oReady,
  output logic       oInitDone,
  output logic [3:0] oLCD_Data,
  output logic       oLCD_RegisterSelect,
  output logic       oLCD_ReadWrite,
  output logic       oWriteStart,
  input  logic       iWriteDone,
  output logic       oError
);

  typedef enum logic [2:0] {
    PWR_WAIT,
    NIB_SETUP,
    NIB_START,
    NIB_WAIT,
    DLY_WAIT,
    IDLE
  } state_t;

  // Steps 0..3 are single init nibbles, 4..7 configuration bytes, 8 a user byte.
  localparam logic [3:0] STEP_FIRST_BYTE = 4'd4;
  localparam logic [3:0] STEP_LAST_CFG   = 4'd7;
  localparam logic [3:0] STEP_USER       = 4'd8;

  // Byte loaded for each init step; single-nibble steps carry the nibble in [7:4].
  function automatic logic [7:0] init_byte(input logic [3:0] step);
    case (step)
      4'd0, 4'd1, 4'd2: init_byte = 8'h30;
      4'd3:             init_byte = 8'h20;
      4'd4:             init_byte = 8'h28;
      4'd5:             init_byte = 8'h06;
      4'd6:             init_byte = 8'h0C;
      4'd7:             init_byte = 8'h01;
      default:          init_byte = 8'h00;
    endcase
  endfunction

  state_t             r_state, w_state_next;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next;
  logic [3:0]         r_step, w_step_next;
  logic               r_low, w_low_next;
  logic [7:0]         r_byte, w_byte_next;
  logic               r_rs, w_rs_next;
  logic               r_init_done, w_init_done_next;
  logic [CNT_W-1:0]   w_delay_target;
  logic               w_delay_last;
  logic               w_nib_active;
  logic               w_ready;
  logic               w_nib_done;

`ifdef LCD_WRITE_WATCHDOG_EN
  logic [6:0] r_wdog;
  logic       r_error;
  logic       w_wdog_expire;

  assign w_wdog_expire = (r_state == NIB_WAIT) && !iWriteDone && (r_wdog == 7'd99);
  assign w_nib_done    = iWriteDone | w_wdog_expire;
  assign oError        = r_error;

  // Watchdog: restarts on every enable request, counts NIB_WAIT cycles, latches the error.
  always_ff @(posedge Clock or negedge iReset) begin
    if (!iReset) begin
      r_wdog  <= '0;
      r_error <= 1'b0;
    end else begin
      if (r_state == NIB_START)     r_wdog <= '0;
      else if (r_state == NIB_WAIT) r_wdog <= r_wdog + 7'd1;
      if (w_wdog_expire)            r_error <= 1'b1;
    end
  end
`else
  assign w_nib_done = iWriteDone;
  assign oError     = 1'b0;
`endif

  // Selects the length of the wait currently in progress.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_delay_target = CNT_W'(T_CMD);
    if (r_state == PWR_WAIT) begin
      w_delay_target = CNT_W'(T_POWERUP);
    end else if (r_step < STEP_FIRST_BYTE) begin
      case (r_step)
        4'd0:    w_delay_target = CNT_W'(T_INIT1);
        4'd1:    w_delay_target = CNT_W'(T_INIT2);
        default: w_delay_target = CNT_W'(T_CMD);
      endcase
    end else if (!r_low) begin
      w_delay_target = CNT_W'(T_NIBBLE);
    end else if (!r_rs && (r_byte[7:1] <= 7'd1)) begin
      // Clear Display and Return Home need the long execution time.
      w_delay_target = CNT_W'(T_CLEAR);
    end
  end

  assign w_delay_last = (r_cnt == (w_delay_target - CNT_W'(1)));

  // Next-state and datapath-update logic for the sequencer.
  always_comb begin
    w_state_next     = r_state;
    w_step_next      = r_step;
    w_low_next       = r_low;
    w_byte_next      = r_byte;
    w_rs_next        = r_rs;
    w_init_done_next = r_init_done;
    case (r_state)
      PWR_WAIT: begin
        if (w_delay_last) begin
          w_state_next = NIB_SETUP;
          w_step_next  = 4'd0;
          w_low_next   = 1'b0;
          w_byte_next  = init_byte(4'd0);
          w_rs_next    = 1'b0;
        end
      end
      NIB_SETUP: w_state_next = NIB_START;
      NIB_START: w_state_next = NIB_WAIT;
      NIB_WAIT: begin
        if (w_nib_done) w_state_next = DLY_WAIT;
      end
      DLY_WAIT: begin
        if (w_delay_last) begin
          if ((r_step < STEP_FIRST_BYTE) || r_low) begin
            // Current item fully written: go idle or move to the next init item.
            if (r_step == STEP_USER) begin
              w_state_next = IDLE;
            end else if (r_step == STEP_LAST_CFG) begin
              w_state_next     = IDLE;
              w_init_done_next = 1'b1;
            end else begin
              w_state_next = NIB_SETUP;
              w_step_next  = r_step + 4'd1;
              w_low_next   = 1'b0;
              w_byte_next  = init_byte(r_step + 4'd1);
              w_rs_next    = 1'b0;
            end
          end else begin
            w_state_next = NIB_SETUP;
            w_low_next   = 1'b1;
          end
        end
      end
      IDLE: begin
        if (iValid && w_ready) begin
          w_state_next = NIB_SETUP;
          w_step_next  = STEP_USER;
          w_low_next   = 1'b0;
          w_byte_next  = iData;
          w_rs_next    = iRS;
        end
      end
      default: w_state_next = PWR_WAIT;
    endcase

    // Delay counter runs only inside a wait state and restarts on any state change.
    if (w_state_next != r_state) begin
      w_cnt_next = '0;
    end else if ((r_state == PWR_WAIT) || (r_state == DLY_WAIT)) begin
      w_cnt_next = r_cnt + CNT_W'(1);
    end else begin
      w_cnt_next = '0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge Clock or negedge iReset) begin
    if (!iReset) begin
      r_state     <= PWR_WAIT;
      r_cnt       <= '0;
      r_step      <= '0;
      r_low       <= 1'b0;
      r_byte      <= '0;
      r_rs        <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_step      <= w_step_next;
      r_low       <= w_low_next;
      r_byte      <= w_byte_next;
      r_rs        <= w_rs_next;
      r_init_done <= w_init_done_next;
    end
  end

  assign w_nib_active        = (r_state == NIB_SETUP) || (r_state == NIB_START) ||
                               (r_state == NIB_WAIT);
  assign w_ready             = (r_state == IDLE) && r_init_done;
  assign oReady              = w_ready;
  assign oInitDone           = r_init_done;
  assign oLCD_Data           = w_nib_active ? (r_low ? r_byte[3:0] : r_byte[7:4]) : 4'h0;
  assign oLCD_RegisterSelect = w_nib_active & r_rs;
  assign oLCD_ReadWrite      = 1'b0;
  assign oWriteStart         = (r_state == NIB_START);

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// tb_lcd_write_sequencer
// Directed bench for lcd_write_sequencer with short timing parameters.
// A pulse-generator model answers each oWriteStart with iWriteDone three cycles later.
// Expected {RS, nibble} pairs are queued as stimulus is applied and popped on each oWriteStart.
module tb_lcd_write_sequencer;

  localparam int T_POWERUP = 20;
  localparam int T_INIT1   = 10;
  localparam int T_INIT2   = 5;
  localparam int T_NIBBLE  = 2;
  localparam int T_CMD     = 4;
  localparam int T_CLEAR   = 8;

  logic       Clock = 1'b0;
  logic       iReset = 1'b0;
  logic [7:0] iData = 8'h00;
  logic       iRS = 1'b0;
  logic       iValid = 1'b0;
  logic       iWriteDone = 1'b0;
  logic       oReady, oInitDone, oLCD_RegisterSelect, oLCD_ReadWrite, oWriteStart, oError;
  logic [3:0] oLCD_Data;

  lcd_write_sequencer #(
    .T_POWERUP(T_POWERUP), .T_INIT1(T_INIT1), .T_INIT2(T_INIT2),
    .T_NIBBLE(T_NIBBLE), .T_CMD(T_CMD), .T_CLEAR(T_CLEAR), .CNT_W(20)
  ) dut (
    .Clock(Clock), .iReset(iReset), .iData(iData), .iRS(iRS), .iValid(iValid),
    .oReady(oReady), .oInitDone(oInitDone), .oLCD_Data(oLCD_Data),
    .oLCD_RegisterSelect(oLCD_RegisterSelect), .oLCD_ReadWrite(oLCD_ReadWrite),
    .oWriteStart(oWriteStart), .iWriteDone(iWriteDone), .oError(oError)
  );

  always #5 Clock = ~Clock;

  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         n_starts = 0;
  int         last_start = -1;
  int         prev_start = -1;
  int         last_done = -1;
  bit         mdl_en = 1'b1;
  int         mdl_cnt = 0;
  logic [4:0] sb_q[$];
  logic [3:0] init_nibs [12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8,
                                 4'h0, 4'h6, 4'h0, 4'hC, 4'h0, 4'h1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Cycle counter; remembers the edge at which the DUT samples iWriteDone high.
  always @(posedge Clock) begin
    cyc++;
    if (iWriteDone) last_done = cyc;
  end

  // Enable-pulse generator model: iWriteDone for one cycle, three cycles after oWriteStart.
  always @(negedge Clock) begin
    if (!iReset) begin
      mdl_cnt    = 0;
      iWriteDone = 1'b0;
    end else begin
      iWriteDone = 1'b0;
      if (oWriteStart && mdl_en) begin
        mdl_cnt = 3;
      end else if (mdl_cnt > 0) begin
        mdl_cnt--;
        if (mdl_cnt == 0) iWriteDone = 1'b1;
      end
    end
  end

  // Scoreboard check on every enable request.
  always @(negedge Clock) begin
    logic [4:0] e;
    if (oWriteStart) begin
      n_starts++;
      prev_start = last_start;
      last_start = cyc;
      check("start_expected", (sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("lcd_rs_nibble", {oLCD_RegisterSelect, oLCD_Data}, e);
      end
      check("rw_low", oLCD_ReadWrite, 0);
    end
  end

  task automatic push_init();
    for (int i = 0; i < 12; i++) sb_q.push_back({1'b0, init_nibs[i]});
  endtask

  task automatic wait_starts(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (n_starts >= target) break;
      @(negedge Clock);
    end
    check("start_within_budget", (n_starts >= target), 1);
  endtask

  task automatic wait_ready(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge Clock);
      if (oReady) begin
        at = cyc;
        break;
      end
    end
    check("ready_within_budget", (at >= 0), 1);
  endtask

  task automatic wait_init(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge Clock);
      if (oInitDone) begin
        at = cyc;
        break;
      end
    end
    check("init_within_budget", (at >= 0), 1);
  endtask

  // Called at a negedge where oReady is high: present one byte for one cycle.
  task automatic send(input logic [7:0] d, input logic rs);
    iData  = d;
    iRS    = rs;
    iValid = 1'b1;
    sb_q.push_back({rs, d[7:4]});
    sb_q.push_back({rs, d[3:0]});
    @(negedge Clock);
    iValid = 1'b0;
    check("ready_drop", oReady, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, observed cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int rel, at, base, s;

    // Reset state.
    repeat (3) @(negedge Clock);
    check("rst_ready", oReady, 0);
    check("rst_init_done", oInitDone, 0);
    check("rst_data", oLCD_Data, 0);
    check("rst_rs", oLCD_RegisterSelect, 0);
    check("rst_rw", oLCD_ReadWrite, 0);
    check("rst_start", oWriteStart, 0);
    check("rst_error", oError, 0);

    // Init sequence, with iValid asserted early on (must be ignored).
    push_init();
    base   = n_starts;
    iData  = 8'hA5;
    iRS    = 1'b1;
    iValid = 1'b1;
    #2 iReset = 1'b1;
    rel = cyc;
    wait_starts(base + 1, 100);
    check("first_start_latency", last_start - rel, 21);
    repeat (20) @(negedge Clock);
    iValid = 1'b0;
    wait_init(1000, at);
    check("init_done_latency", at - last_done, 8);
    check("init_start_count", n_starts - base, 12);
    check("init_sb_empty", sb_q.size(), 0);
    @(negedge Clock);
    check("ready_after_init", oReady, 1);

    // Data byte 0x41.
    base = n_starts;
    send(8'h41, 1'b1);
    wait_ready(200, at);
    check("gap_41", last_start - prev_start, 7);
    check("post_wait_41", at - last_done, T_CMD);
    check("starts_41", n_starts - base, 2);

    // Clear display, then a normal command.
    send(8'h01, 1'b0);
    wait_ready(200, at);
    check("post_wait_clear", at - last_done, T_CLEAR);
    send(8'h80, 1'b0);
    wait_ready(200, at);
    check("post_wait_cmd", at - last_done, T_CMD);

    // iValid held high while iData changes during the busy period.
    base   = n_starts;
    iData  = 8'h55;
    iRS    = 1'b1;
    iValid = 1'b1;
    sb_q.push_back({1'b1, 4'h5});
    sb_q.push_back({1'b1, 4'h5});
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      iData = iData + 8'h37;
    end
    iValid = 1'b0;
    wait_ready(200, at);
    check("busy_start_count", n_starts - base, 2);
    repeat (10) @(negedge Clock);
    check("busy_no_extra_start", n_starts - base, 2);
    check("busy_sb_empty", sb_q.size(), 0);

    // Reset during the low-nibble NIB_WAIT.
    base = n_starts;
    send(8'h7E, 1'b1);
    wait_starts(base + 2, 100);
    @(negedge Clock);
    check("nib_wait_data_held", oLCD_Data, 4'hE);
    check("nib_wait_rs_held", oLCD_RegisterSelect, 1);
    #2 iReset = 1'b0;
    #1;
    check("abort_data", oLCD_Data, 0);
    check("abort_rs", oLCD_RegisterSelect, 0);
    check("abort_start", oWriteStart, 0);
    check("abort_ready", oReady, 0);
    check("abort_init_done", oInitDone, 0);
    sb_q.delete();
    repeat (3) @(negedge Clock);
    push_init();
    base = n_starts;
    #2 iReset = 1'b1;
    rel = cyc;
    @(negedge Clock);
    check("restart_init_done_low", oInitDone, 0);
    wait_starts(base + 1, 100);
    check("restart_first_start_latency", last_start - rel, 21);
    wait_init(1000, at);
    check("restart_start_count", n_starts - base, 12);

`ifdef LCD_WRITE_WATCHDOG_EN
    // Pulse generator never answers: watchdog flags and the byte still completes.
    mdl_en = 1'b0;
    base   = n_starts;
    send(8'h42, 1'b1);
    wait_starts(base + 1, 50);
    s  = last_start;
    at = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge Clock);
      if (oError) begin
        at = cyc;
        break;
      end
    end
    check("wdog_latency", at - s, 101);
    wait_starts(base + 2, 200);
    check("wdog_error_sticky_mid", oError, 1);
    wait_ready(600, at);
    check("wdog_error_sticky_end", oError, 1);
    check("wdog_start_count", n_starts - base, 2);
    @(negedge Clock);
    #2 iReset = 1'b0;
    #1;
    check("wdog_error_cleared", oError, 0);
    mdl_en = 1'b1;
`else
    check("error_tied_low", oError, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lcd_write_sequencer.md
Name: lcd_write_sequencer

Overview:
- Controller for the Spartan-3E character LCD 4-bit write path.
- After reset it runs the HD44780 power-on initialisation sequence. It then accepts byte commands and characters over a valid/ready handshake.
- Each byte is split into two nibbles. For each nibble the block drives data/RS/RW and requests one enable pulse from the enable-pulse generator via a start/done handshake.
- It inserts every required settling delay between nibbles and between commands.

Parameters:
- T_POWERUP, 750000: cycles before the first init nibble (15 ms at 50 MHz).
- T_INIT1, 205000: wait after the first 0x3 nibble (4.1 ms).
- T_INIT2, 5000: wait after the second 0x3 nibble (100 us).
- T_NIBBLE, 50: gap between the high and low nibble of one byte (1 us).
- T_CMD, 2000: post-byte wait for normal commands and data (40 us).
- T_CLEAR, 82000: post-byte wait for Clear Display / Return Home (1.64 ms).
- CNT_W, 20: delay counter width; must hold the largest T_*.

Ports:
- Clock, in, 1: system clock; all state changes on the rising edge.
- iReset, in, 1: asynchronous, active-low reset.
- iData, in, 8: byte to write.
- iRS, in, 1: register select for iData (0 = command, 1 = data).
- iValid, in, 1: iData/iRS are valid.
- oReady, out, 1: block can accept a byte this cycle.
- oInitDone, out, 1: init sequence complete; stays high until reset.
- oLCD_Data, out, 4: LCD DB[7:4].
- oLCD_RegisterSelect, out, 1: LCD RS.
- oLCD_ReadWrite, out, 1: LCD RW; always 0 (write only).
- oWriteStart, out, 1: one-cycle request to the enable-pulse generator.
- iWriteDone, in, 1: pulse generator finished the enable pulse (level).
- oError, out, 1: sticky watchdog flag (only when the optional feature is compiled in, else tied 0).

Behaviour:
- Reset (iReset=0, asynchronous): all outputs 0, state PWR_WAIT, delay counter 0, init step index 0, data latch 0. Reset mid-operation aborts immediately; init restarts from PWR_WAIT after release.
- Delay counter: counts up from 0 each cycle while in a WAIT state. The state exits when count == T_x-1, so the wait lasts exactly T_x cycles. The counter clears on every state change.
- Nibble write sub-sequence (NIB_SETUP -> NIB_START -> NIB_WAIT):
  - NIB_SETUP drives oLCD_Data/oLCD_RegisterSelect for 1 cycle.
  - NIB_START asserts oWriteStart for exactly 1 cycle.
  - NIB_WAIT holds data/RS stable until iWriteDone=1 is sampled. iWriteDone is ignored in the NIB_START cycle itself.
- Init states, in order: PWR_WAIT(T_POWERUP) -> nibble 0x3 -> WAIT(T_INIT1) -> 0x3 -> WAIT(T_INIT2) -> 0x3 -> WAIT(T_CMD) -> 0x2 -> WAIT(T_CMD).
- Config bytes, all RS=0: 0x28, 0x06, 0x0C, 0x01. Each is sent as a full byte (below). After 0x01 the block sets oInitDone=1 and enters IDLE.
- IDLE: oReady=1 only here and only with oInitDone=1. On iValid=1 && oReady=1 at a rising edge, iData/iRS are latched and oReady drops the next cycle. iData changes while busy are ignored.
- Byte sequence:
  - High nibble write.
  - WAIT(T_NIBBLE).
  - Low nibble write.
  - WAIT(T_CLEAR) if RS=0 and byte[7:1]==7'b0000000 (0x01 clear) or byte[7:1]==7'b0000001 (0x02/0x03 home); otherwise WAIT(T_CMD).
  - Return to IDLE.
- Throughput: no back-to-back acceptance. oReady is low from the cycle after acceptance until the post-byte wait ends.
- iValid during init: ignored, not queued.
- oLCD_ReadWrite = 0 at all times, including reset.

Optional Feature:
- Macro: LCD_WRITE_WATCHDOG_EN.
- Defined:
  - A 7-bit watchdog counts cycles in NIB_WAIT. If iWriteDone is not seen within 100 cycles, oError is set (sticky until reset) and the sequencer proceeds as if done.
  - The watchdog clears on every NIB_START.
- Undefined: no watchdog; NIB_WAIT waits indefinitely; oError tied 0.

Test Plan:
- Use T_POWERUP=20, T_INIT1=10, T_INIT2=5, T_NIBBLE=2, T_CMD=4, T_CLEAR=8. The pulse-generator model returns iWriteDone 3 cycles after oWriteStart.
- Reset release -> oLCD_Data nibble sequence 3,3,3,2,2,8,0,6,0,C,0,1; RS=0 throughout; oWriteStart pulse count 12; oInitDone rises 8 cycles after the last iWriteDone; oReady=1 next cycle.
- After init, iData=0x41, iRS=1, iValid one cycle -> nibbles 4 then 1 with RS=1; gap between the two oWriteStart pulses = 3+1+2+1 cycles; oReady returns 4 cycles after the second iWriteDone.
- iData=0x01, iRS=0 -> post-byte wait is 8 cycles (T_CLEAR); then iData=0x80, iRS=0 -> wait 4 cycles (T_CMD).
- iValid held high with changing iData while busy -> only the byte present at the acceptance edge is written; no extra oWriteStart pulses.
- Assert iReset=0 during the low-nibble NIB_WAIT -> all outputs 0 asynchronously; after release, oInitDone=0 and PWR_WAIT restarts (first oWriteStart 21 cycles later).
- LCD_WRITE_WATCHDOG_EN defined and the model never returns iWriteDone -> oError=1 after 100 cycles; the sequence continues; oError stays 1 until reset.
